// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pc_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  // Fetch FSM: FETCH has a request on the bus, IDLE waits for buffer space,
  // DRAIN keeps a wrong-path request alive until its response is discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IDLE  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam u64 RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // Redirect targets are word aligned on capture; misalignment is flagged upstream.
  function automatic u64 word_align(input u64 addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch PC owner: single outstanding instruction-bus request, one-entry
// output buffer toward decode, branch redirect with wrong-path discard.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter u64 RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [63:0] jump,
  output logic        imem_valid,
  output logic [63:0] imem_addr,
  input  logic        imem_data_ok,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           req_addr_q, req_addr_d;
  u1            out_valid_q, out_valid_d;
  u64           out_pc_q, out_pc_d;
  u32           out_instr_q, out_instr_d;
  // Low during reset and for the first cycle after release so the bus
  // request only appears on the first edge after deassertion.
  u1            run_q;
  u1            consume;
  u64           jump_a;

  assign consume = out_valid_q & out_ready;
  assign jump_a  = word_align(jump);

  // Next-state decode: redirect has priority over every state transition.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (consume) begin
      out_valid_d = 1'b0;
    end
    if (branch) begin
      out_valid_d = 1'b0;
      pc_d        = jump_a;
      case (state_q)
        FETCH: begin
          if (imem_data_ok) begin
            req_addr_d = jump_a;
          end else begin
            state_d = DRAIN;
          end
        end
        IDLE: begin
          req_addr_d = jump_a;
          state_d    = FETCH;
        end
        DRAIN: begin
          if (imem_data_ok) begin
            req_addr_d = jump_a;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_data_ok) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_addr_q;
            out_instr_d = imem_data;
            pc_d        = req_addr_q + 64'd4;
            state_d     = IDLE;
          end
        end
        IDLE: begin
          if (!out_valid_q || consume) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (imem_data_ok) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and output buffer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      run_q       <= 1'b1;
    end
  end

  assign imem_valid = run_q && (state_q != IDLE);
  assign imem_addr  = req_addr_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: responding memory model, expected-instruction queue,
// and directed redirect / stall / reset scenarios.
module tb_fetch_pc;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch;
  logic [63:0] jump;
  logic        imem_valid;
  logic [63:0] imem_addr;
  logic        imem_data_ok;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  fetch_pc #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .branch       (branch),
    .jump         (jump),
    .imem_valid   (imem_valid),
    .imem_addr    (imem_addr),
    .imem_data_ok (imem_data_ok),
    .imem_data    (imem_data),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_ready    (out_ready)
  );

  initial forever #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  exp_t        sb_q[$];
  logic        busy;
  logic        wp;
  int          cnt;
  int          lat;
  logic [63:0] paddr;
  logic [63:0] exp_next;
  logic        bo_arm;
  logic [63:0] bo_target;
  logic        bo_fired;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1300_0013;
  endfunction

  // One clock: memory model and scoreboard act on the pre-edge view, then
  // outputs are inspected 1ns after the rising edge.
  task automatic step();
    logic loaded;
    logic flushed;
    logic [63:0] ld_pc;
    loaded   = 1'b0;
    flushed  = 1'b0;
    ld_pc    = '0;
    bo_fired = 1'b0;
    imem_data_ok = 1'b0;
    if (busy) begin
      chk("addr_hold_v", 64'(imem_valid), 64'd1);
      chk("addr_hold_a", imem_addr, paddr);
      cnt++;
      if (cnt >= lat) begin
        imem_data_ok = 1'b1;
        imem_data    = instr_of(paddr);
      end
    end else if (imem_valid) begin
      chk("req_addr", imem_addr, exp_next);
      busy  = 1'b1;
      wp    = 1'b0;
      paddr = imem_addr;
      cnt   = 0;
      if (lat == 0) begin
        imem_data_ok = 1'b1;
        imem_data    = instr_of(paddr);
      end
    end
    if (bo_arm && imem_data_ok) begin
      branch   = 1'b1;
      jump     = bo_target;
      bo_arm   = 1'b0;
      bo_fired = 1'b1;
    end
    if (out_valid && out_ready && !branch) begin
      chk("sb_depth", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_pop++;
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", 64'(out_instr), 64'(e.ins));
      end
    end
    if (imem_data_ok && !branch && !wp) begin
      sb_q.push_back('{pc: paddr, ins: instr_of(paddr)});
      exp_next = paddr + 64'd4;
      loaded   = 1'b1;
      ld_pc    = paddr;
    end
    if (branch) begin
      if (busy && !imem_data_ok) wp = 1'b1;
      sb_q.delete();
      exp_next = jump & ~64'h3;
      flushed  = 1'b1;
    end
    @(posedge clk);
    #1;
    if (imem_data_ok) busy = 1'b0;
    imem_data_ok = 1'b0;
    branch       = 1'b0;
    if (loaded) begin
      chk("buf_load", 64'(out_valid), 64'd1);
      chk("buf_pc", out_pc, ld_pc);
    end
    if (flushed) chk("flush", 64'(out_valid), 64'd0);
  endtask

  task automatic bench_reset_state();
    busy = 1'b0;
    wp   = 1'b0;
    cnt  = 0;
    sb_q.delete();
    exp_next     = RST_PC;
    branch       = 1'b0;
    imem_data_ok = 1'b0;
    bo_arm       = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_imem_lo", 64'(imem_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("first_req_v", 64'(imem_valid), 64'd1);
    chk("first_req_a", imem_addr, RST_PC);
  endtask

  initial begin
    logic [63:0] held;
    reset     = 1'b0;
    jump      = '0;
    imem_data = '0;
    out_ready = 1'b1;
    lat       = 1;
    bench_reset_state();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_valid", 64'(imem_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    release_reset();

    // Straight-line fetch with a one-cycle memory and decode always ready.
    repeat (12) step();
    chk("seq_count_ge3", 64'(n_pop >= 3), 64'd1);

    // Decode stall with the buffer full.
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    chk("stall_full", 64'(out_valid), 64'd1);
    held = out_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_req", 64'(imem_valid), 64'd0);
      chk("stall_pc", out_pc, held);
    end
    out_ready = 1'b1;
    step();
    chk("resume_v", 64'(imem_valid), 64'd1);
    chk("resume_addr", imem_addr, held + 64'd4);

    // Redirect while a slow request is outstanding.
    lat = 3;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("slow_busy", 64'(busy), 64'd1);
    branch = 1'b1;
    jump   = 64'h0000_0000_8000_0100;
    step();
    repeat (10) step();

    // Redirect coincident with the response.
    lat       = 1;
    bo_arm    = 1'b1;
    bo_target = 64'h0000_0000_8000_0400;
    for (int i = 0; i < 10 && !bo_fired; i++) step();
    chk("coinc_fired", 64'(bo_fired), 64'd1);
    chk("coinc_req_v", 64'(imem_valid), 64'd1);
    chk("coinc_req_a", imem_addr, 64'h0000_0000_8000_0400);
    repeat (6) step();

    // Two redirects while draining; the second target has stray low bits.
    lat = 4;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("drain_busy", 64'(busy), 64'd1);
    branch = 1'b1;
    jump   = 64'h0000_0000_8000_0200;
    step();
    branch = 1'b1;
    jump   = 64'h0000_0000_8000_0303;
    step();
    repeat (14) step();

    // PC wraps at the top of the address space.
    lat = 1;
    for (int i = 0; i < 10 && busy; i++) step();
    branch = 1'b1;
    jump   = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    repeat (8) step();

    // Asynchronous reset in the middle of a request.
    lat = 3;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("arst_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_imem_valid", 64'(imem_valid), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_imem_addr", imem_addr, RST_PC);
    bench_reset_state();
    lat = 1;
    @(posedge clk);
    release_reset();
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
